// File: rtl/sensor_pkg.sv
// Shared types and defaults for the four-channel ultrasonic scan controller.
// Parameter defaults assume a 50 MHz clock driving HC-SR04 style sensors.
package sensor_pkg;

   localparam int NUM_SENSORS = 4;
   localparam int SEL_W       = $clog2(NUM_SENSORS);
   localparam int DIST_W      = 8;

   localparam int DEF_TRIG_CYCLES   = 500;
   localparam int DEF_CYCLES_PER_CM = 2950;
   localparam int DEF_MAX_CM        = 101;
   localparam int DEF_ECHO_TIMEOUT  = 1500000;
   localparam int DEF_GAP_CYCLES    = 3000000;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_TRIG      = 3'd1,
      S_WAIT_ECHO = 3'd2,
      S_MEASURE   = 3'd3,
      S_STORE     = 3'd4,
      S_GAP       = 3'd5
   } state_t;

endpackage

// File: rtl/sensor_scan_controller_echo_timer.sv
// Echo pulse timing for one shot: cm prescaler, saturating cm counter, shot timeout.
// Counts update one cycle after the qualifying input; no backpressure.
module echo_timer
   import sensor_pkg::*;
#(
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int MAX_CM        = DEF_MAX_CM,
   parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              run_i,
   input  logic              count_i,
   output logic [DIST_W-1:0] cm_o,
   output logic              timeout_o
);

   localparam int PRE_W = $clog2(CYCLES_PER_CM);
   localparam int CM_W  = $clog2(MAX_CM + 1);
   localparam int TMR_W = $clog2(ECHO_TIMEOUT);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_CM - 1);
   localparam logic [CM_W-1:0]  CM_MAX   = CM_W'(MAX_CM);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ECHO_TIMEOUT - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CM_W-1:0]  cm_q, cm_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   always_comb begin
      pre_d = pre_q;
      cm_d  = cm_q;
      tmr_d = tmr_q;
      if (clear_i) begin
         pre_d = '0;
         cm_d  = '0;
         tmr_d = '0;
      end else begin
         // Timer parks on its last value so it can never wrap.
         if (run_i && (tmr_q != TMR_LAST)) tmr_d = tmr_q + 1'b1;
         if (count_i) begin
            if (pre_q == PRE_LAST) begin
               pre_d = '0;
               if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
         cm_q  <= '0;
         tmr_q <= '0;
      end else begin
         pre_q <= pre_d;
         cm_q  <= cm_d;
         tmr_q <= tmr_d;
      end
   end

   assign timeout_o = run_i && (tmr_q == TMR_LAST);
   assign cm_o      = DIST_W'(cm_q);

endmodule

// File: rtl/sensor_scan_controller.sv
// Round-robin HC-SR04 scanner: trigger, time the echo, store distance in cm, settle.
// Echo seen 2 cycles late through synchronizers; result visible in the sample_valid cycle; no backpressure.
module sensor_scan_controller
   import sensor_pkg::*;
#(
   parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int MAX_CM        = DEF_MAX_CM,
   parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
   parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [NUM_SENSORS-1:0]        echo,
   output logic [NUM_SENSORS-1:0]        trig,
   output logic [NUM_SENSORS*DIST_W-1:0] dist_all,
   output logic [NUM_SENSORS-1:0]        timeout_flags,
   output logic                          sample_valid,
   output logic [SEL_W-1:0]              sample_idx,
   output logic                          scan_done,
   output logic                          busy
);

   localparam int PH_MAX = (GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX);

   localparam logic [PH_W-1:0]   TRIG_LAST = PH_W'(TRIG_CYCLES - 1);
   localparam logic [PH_W-1:0]   GAP_LAST  = PH_W'(GAP_CYCLES - 1);
   localparam logic [DIST_W-1:0] DIST_MAX  = DIST_W'(MAX_CM);
   localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_SENSORS - 1);

   state_t                               state_q, state_d;
   logic [SEL_W-1:0]                     sel_q, sel_d;
   logic [PH_W-1:0]                      ph_q, ph_d;
   logic [NUM_SENSORS-1:0][DIST_W-1:0]   dist_q, dist_d;
   logic [NUM_SENSORS-1:0]               flag_q, flag_d;
   logic [NUM_SENSORS-1:0]               sync1_q, sync2_q;

   logic              echo_sel;
   logic              tmr_timeout;
   logic [DIST_W-1:0] tmr_cm;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= echo;
         sync2_q <= sync1_q;
      end
   end

   assign echo_sel = sync2_q[sel_q];

   echo_timer #(
      .CYCLES_PER_CM (CYCLES_PER_CM),
      .MAX_CM        (MAX_CM),
      .ECHO_TIMEOUT  (ECHO_TIMEOUT)
   ) u_echo_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (state_q == S_TRIG),
      .run_i     ((state_q == S_WAIT_ECHO) || (state_q == S_MEASURE)),
      .count_i   ((state_q == S_MEASURE) && echo_sel),
      .cm_o      (tmr_cm),
      .timeout_o (tmr_timeout)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      ph_d         = '0;
      dist_d       = dist_q;
      flag_d       = flag_q;
      trig         = '0;
      sample_valid = 1'b0;
      scan_done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_TRIG;
         end
         S_TRIG: begin
            trig[sel_q] = 1'b1;
            if (ph_q == TRIG_LAST) state_d = S_WAIT_ECHO;
            else                   ph_d    = ph_q + 1'b1;
         end
         S_WAIT_ECHO, S_MEASURE: begin
            // Result is written on the way into STORE so it is visible with sample_valid.
            if (tmr_timeout) begin
               state_d       = S_STORE;
               dist_d[sel_q] = DIST_MAX;
               flag_d[sel_q] = 1'b1;
            end else if ((state_q == S_WAIT_ECHO) && echo_sel) begin
               state_d = S_MEASURE;
            end else if ((state_q == S_MEASURE) && !echo_sel) begin
               state_d       = S_STORE;
               dist_d[sel_q] = tmr_cm;
               flag_d[sel_q] = 1'b0;
            end
         end
         S_STORE: begin
            sample_valid = 1'b1;
            scan_done    = (sel_q == SEL_LAST);
            state_d      = S_GAP;
         end
         S_GAP: begin
            if (ph_q == GAP_LAST) begin
               sel_d   = sel_q + 1'b1;
               state_d = enable ? S_TRIG : S_IDLE;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         ph_q    <= '0;
         dist_q  <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ph_q    <= ph_d;
         dist_q  <= dist_d;
         flag_q  <= flag_d;
      end
   end

   assign dist_all      = dist_q;
   assign timeout_flags = flag_q;
   assign sample_idx    = sel_q;
   assign busy          = (state_q != S_IDLE);

endmodule
